// File: rtl/hidden_cpu_pkg.sv
// Shared constants for the HiddenCPU program store and fetch stage.
// State encoding is fixed so the debug port can be decoded externally.
package hidden_cpu_pkg;

   localparam int IW_DEF = 6;
   localparam int PCW_DEF = 8;
   localparam logic [5:0] FILL_DEF = 6'b000000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_CRST = 2'd2;
   localparam logic [1:0] ST_RUN  = 2'd3;

endpackage

// File: rtl/hidden_prog_ram.sv
// Program memory: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module hidden_prog_ram #(
   parameter int DEPTH = 16,
   parameter int IW = 6,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   logic [IW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hidden_cpu_ifetch.sv
// Program loader and instruction fetch stage feeding the HiddenCPU core.
// The core is held in reset until a program is committed and released.
module hidden_cpu_ifetch
   import hidden_cpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IW = IW_DEF,
   parameter int PCW = PCW_DEF,
   parameter logic [IW-1:0] FILL = IW'(FILL_DEF),
   localparam int AW = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_start,
   input  logic           abort,
   input  logic           load_valid,
   input  logic [IW-1:0]  load_data,
   input  logic           load_last,
   output logic           load_ready,
   input  logic [PCW-1:0] pc_in,
   output logic [IW-1:0]  instr_out,
   output logic           instr_valid,
   output logic           cpu_rst,
   output logic [AW:0]    prog_len,
   output logic           done,
   output logic [1:0]     state
);

   logic [AW:0]   wr_ptr;
   logic          crst_cnt;
   logic          accept;
   logic          commit;
   logic          past_end;
   logic          in_run;
   logic [IW-1:0] rdata;

   assign in_run = (state == ST_RUN);
   assign cpu_rst = ~in_run;
   assign load_ready = (state == ST_LOAD) &&
                       (wr_ptr < (AW+1)'(DEPTH));

   // A beat landing with abort is discarded along with the program.
   assign accept = load_valid & load_ready & ~abort;
   assign commit = accept &
                   (load_last | (wr_ptr == (AW+1)'(DEPTH - 1)));

   // Full-width unsigned compare so any pc_in >= DEPTH is past end.
   assign past_end = (32'(pc_in) >= 32'(prog_len));

   assign instr_valid = in_run & ~past_end;
   assign instr_out = instr_valid ? rdata : FILL;

   hidden_prog_ram #(
      .DEPTH (DEPTH),
      .IW    (IW),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (load_data),
      .raddr (pc_in[AW-1:0]),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         wr_ptr <= '0;
         prog_len <= '0;
         done <= 1'b0;
         crst_cnt <= 1'b0;
      end else if (abort) begin
         if (state == ST_LOAD) prog_len <= '0;
         state <= ST_IDLE;
         done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_start) begin
                  state <= ST_LOAD;
                  wr_ptr <= '0;
                  prog_len <= '0;
                  done <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (commit) begin
                     prog_len <= wr_ptr + 1'b1;
                     crst_cnt <= 1'b0;
                     state <= ST_CRST;
                  end
               end
            end
            ST_CRST: begin
               crst_cnt <= 1'b1;
               if (crst_cnt) state <= ST_RUN;
            end
            default: begin
               if (load_start) begin
                  state <= ST_LOAD;
                  wr_ptr <= '0;
                  prog_len <= '0;
                  done <= 1'b0;
               end else if (past_end) begin
                  done <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hidden_cpu_ifetch.sv
// Self-checking bench for hidden_cpu_ifetch: directed scenarios with literal
// expectations plus randomized traffic against a behavioural program model.
module tb_hidden_cpu_ifetch;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_start;
   logic       abort;
   logic       load_valid;
   logic [5:0] load_data;
   logic       load_last;
   logic       load_ready;
   logic [7:0] pc_in;
   logic [5:0] instr_out;
   logic       instr_valid;
   logic       cpu_rst;
   logic [4:0] prog_len;
   logic       done;
   logic [1:0] state;

   int n_checks = 0;
   int n_err = 0;

   // Behavioural model: phase, stored program, committed length.
   int         m_mode;
   int         m_cnt;
   int         m_plen;
   int         m_wait;
   bit         m_done;
   logic [5:0] m_prog [16];

   hidden_cpu_ifetch dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .abort       (abort),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .pc_in       (pc_in),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .cpu_rst     (cpu_rst),
      .prog_len    (prog_len),
      .done        (done),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_cnt = 0;
      m_plen = 0;
      m_wait = 0;
      m_done = 1'b0;
   endtask

   task automatic model_step();
      if (!rst) begin
         model_reset();
      end else if (abort) begin
         if (m_mode == 1) m_plen = 0;
         m_mode = 0;
         m_done = 1'b0;
      end else if ((m_mode == 0 || m_mode == 3) && load_start) begin
         m_mode = 1;
         m_cnt = 0;
         m_plen = 0;
         m_done = 1'b0;
      end else if (m_mode == 1) begin
         if (load_valid) begin
            m_prog[m_cnt] = load_data;
            m_cnt++;
            if (load_last || m_cnt == 16) begin
               m_plen = m_cnt;
               m_mode = 2;
               m_wait = 2;
            end
         end
      end else if (m_mode == 2) begin
         m_wait--;
         if (m_wait == 0) m_mode = 3;
      end else if (m_mode == 3) begin
         if (int'(pc_in) >= m_plen) m_done = 1'b1;
      end
   endtask

   task automatic check_all();
      bit         ev;
      logic [5:0] ei;
      #1;
      ev = (m_mode == 3) && (int'(pc_in) < m_plen);
      ei = ev ? m_prog[pc_in[3:0]] : 6'h00;
      chk("state", int'(state), m_mode);
      chk("cpu_rst", int'(cpu_rst), int'(m_mode != 3));
      chk("load_ready", int'(load_ready), int'(m_mode == 1));
      chk("prog_len", int'(prog_len), m_plen);
      chk("done", int'(done), int'(m_done));
      chk("instr_valid", int'(instr_valid), int'(ev));
      chk("instr_out", int'(instr_out), int'(ei));
   endtask

   task automatic tick();
      check_all();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic beat(input logic [5:0] d, input logic last);
      load_valid = 1'b1;
      load_data = d;
      load_last = last;
      tick();
      load_valid = 1'b0;
      load_last = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      load_start = 1'b0;
      abort = 1'b0;
      load_valid = 1'b0;
      load_data = '0;
      load_last = 1'b0;
      pc_in = '0;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_state", int'(state), 0);
      chk("rst_cpu_rst", int'(cpu_rst), 1);
      chk("rst_instr", int'(instr_out), 0);
      rst = 1'b1;
      tick();

      // Asynchronous reset in the middle of a load.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      beat(6'h01, 1'b0);
      beat(6'h02, 1'b0);
      beat(6'h03, 1'b0);
      chk("mid_load_state", int'(state), 1);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("async_state", int'(state), 0);
      chk("async_prog_len", int'(prog_len), 0);
      chk("async_cpu_rst", int'(cpu_rst), 1);
      chk("async_load_ready", int'(load_ready), 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Four-word program with last on beat 4.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      beat(6'h11, 1'b0);
      beat(6'h22, 1'b0);
      beat(6'h05, 1'b0);
      beat(6'h3F, 1'b1);
      #1;
      chk("p4_state_crst", int'(state), 2);
      chk("p4_len", int'(prog_len), 4);
      chk("p4_ready_drop", int'(load_ready), 0);
      tick();
      chk("p4_crst2", int'(cpu_rst), 1);
      tick();
      chk("p4_run", int'(state), 3);
      chk("p4_run_rst", int'(cpu_rst), 0);
      pc_in = 8'd2;
      #1;
      chk("p4_pc2_instr", int'(instr_out), 'h05);
      chk("p4_pc2_valid", int'(instr_valid), 1);
      tick();
      pc_in = 8'd4;
      #1;
      chk("p4_pc4_instr", int'(instr_out), 0);
      chk("p4_pc4_valid", int'(instr_valid), 0);
      tick();
      pc_in = 8'd0;
      tick();
      chk("p4_done_sticky", int'(done), 1);
      chk("p4_pc0_instr", int'(instr_out), 'h11);

      // Reload from RUN, 16 beats with gaps and no last.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("reload_state", int'(state), 1);
      chk("reload_cpu_rst", int'(cpu_rst), 1);
      chk("reload_done", int'(done), 0);
      for (int i = 0; i < 16; i++) begin
         beat(6'($urandom), 1'b0);
         load_data = 6'($urandom);
         tick();
      end
      chk("full_len", int'(prog_len), 16);
      chk("full_ready", int'(load_ready), 0);
      tick();
      for (int i = 0; i < 16; i++) begin
         pc_in = 8'(i);
         tick();
      end
      chk("full_no_done", int'(done), 0);
      pc_in = 8'h10;
      tick();
      chk("full_done", int'(done), 1);

      // Abort during a load, together with load_start.
      pc_in = 8'd0;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      beat(6'h2A, 1'b0);
      beat(6'h15, 1'b0);
      abort = 1'b1;
      load_start = 1'b1;
      load_valid = 1'b1;
      tick();
      abort = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      chk("abort_state", int'(state), 0);
      chk("abort_len", int'(prog_len), 0);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         abort = ($urandom_range(0, 99) == 0);
         load_start = ($urandom_range(0, 24) == 0);
         load_valid = 1'($urandom_range(0, 1));
         load_last = ($urandom_range(0, 5) == 0);
         load_data = 6'($urandom);
         if ($urandom_range(0, 7) == 0) pc_in = 8'($urandom);
         else pc_in = 8'($urandom_range(0, 17));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/hidden_cpu_ifetch.md
# hidden_cpu_ifetch

Program-store and instruction-fetch stage that sits directly upstream of the HiddenCPU core. It accepts a program of up to 16 six-bit instructions over a valid/ready load port, holds the core in reset while loading, then releases it. In RUN it presents the word addressed by the core's PC on the 6 instruction lines (opcode[1:0] + addrs[3:0]) that the core samples each cycle.

## Interface
Parameters:
- DEPTH, 16, program entries (power of two; index width AW = log2(DEPTH))
- IW, 6, instruction width ({opcode[1:0], addrs[3:0]})
- PCW, 8, core PC width
- FILL, 6'b000000, word driven when no valid instruction is present

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- load_start  in  1  request to enter LOAD
- abort  in  1  return to IDLE from any state
- load_valid  in  1  load beat present
- load_data  in  IW  instruction word for the beat
- load_last  in  1  marks final beat of the program
- load_ready  out  1  high only in LOAD with space left
- pc_in  in  PCW  core program counter
- instr_out  out  IW  instruction to core (drives core opcode/addrs inputs)
- instr_valid  out  1  instr_out comes from program memory
- cpu_rst  out  1  active-high synchronous reset to core
- prog_len  out  AW+1  committed program length, 0..DEPTH
- done  out  1  sticky: PC ran past program end
- state  out  2  FSM state, for debug

## Operation
- States: IDLE=0, LOAD=1, CRST=2, RUN=3.
- IDLE: cpu_rst=1. load_start -> LOAD; wr_ptr<=0.
- LOAD: cpu_rst=1, load_ready=1. Beat accepted on load_valid & load_ready: mem[wr_ptr]<=load_data, wr_ptr++. Accepted beat with load_last, or the DEPTH-th accepted beat (load_last ignored) -> commit prog_len<=wr_ptr+1, go CRST.
- CRST: cpu_rst=1 for exactly 2 cycles (counter), then RUN.
- RUN: cpu_rst=0. If pc_in < prog_len: instr_out=mem[pc_in[AW-1:0]], instr_valid=1. Else instr_out=FILL, instr_valid=0, done<=1 (sticky until next LOAD entry or IDLE).
- load_start in RUN -> LOAD (cpu_rst reasserted combinationally from state). load_start in LOAD/CRST ignored.
- abort in any state -> IDLE next edge; abort in LOAD discards partial program and sets prog_len<=0. abort and load_start together: abort wins.
- Entering LOAD clears done and sets prog_len<=0.
- Outside RUN: instr_out=FILL, instr_valid=0.
- PC comparison is unsigned, full PCW width; pc_in >= DEPTH always counts as past end.

## Timing
- Reset (rst=0, async): state=IDLE, wr_ptr=0, prog_len=0, done=0, cpu_rst=1, load_ready=0, instr_out=FILL, instr_valid=0. Program memory not reset.
- instr_out/instr_valid are combinational from pc_in and mem in RUN (zero latency), matching the core's same-cycle sampling of its instruction lines.
- cpu_rst, load_ready decoded from registered state only (no input-to-output paths).
- Load throughput 1 beat/cycle; load_ready drops the cycle after the committing beat.
- First RUN cycle follows 2 CRST cycles; the core sees pc_in=0 there, since cpu_rst held it in reset.
- A write and a RUN read never coincide (exclusive states).

## Structure
- Package hidden_cpu_pkg: state encoding constants, FILL default, IW/PCW defaults.
- One sub-module: hidden_prog_ram (DEPTH x IW, 1 sync write port, 1 async read port, no reset).
- FSM, wr_ptr, CRST counter, prog_len, done in the top.

## Test plan
- Reset: rst=0 mid-LOAD after 3 beats -> state=0, prog_len=0, cpu_rst=1, load_ready=0 immediately (async).
- Load 4 words 0x11,0x22,0x05,0x3F with last on beat 4 -> prog_len=4, cpu_rst high 2 cycles in CRST, then RUN; pc_in=2 -> instr_out=0x05, instr_valid=1.
- Past end: prog_len=4, pc_in=4 -> instr_out=FILL, instr_valid=0, done=1; done stays 1 after pc_in returns to 0.
- Full: 16 beats, load_last never asserted -> commit on 16th, prog_len=16, load_ready=0 next cycle; pc_in=0x10 -> done=1.
- Backpressure/gaps: load_valid toggled 1,0,1,0 -> only handshaked beats written, wr_ptr correct, contents verified via pc_in readback.
- abort in LOAD after 2 beats with load_start same cycle -> IDLE, prog_len=0; load_start in RUN -> LOAD, cpu_rst=1, done cleared.
